// File: rtl/dpseq_pkg.sv
// dpseq_pkg: shared types and encodings for datapath_sequencer.
//   Opcode and state enums, datapath mux/ALU encodings, the control-word
//   struct driven onto the datapath, the decoder result struct and the
//   idle control-word constant.
package dpseq_pkg;

   localparam int unsigned OP_W  = 3;
   localparam int unsigned REG_W = 2;

   typedef enum logic [2:0] {
      OP_LOAD = 3'b000,
      OP_MOV  = 3'b001,
      OP_XOR  = 3'b010,
      OP_AND  = 3'b011,
      OP_SHL  = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LDT  = 2'b01,
      S_WB   = 2'b10,
      S_RET  = 2'b11
   } state_e;

   // write-data mux
   localparam logic [1:0] SR_IN  = 2'b00;
   localparam logic [1:0] SR_ALU = 2'b01;
   localparam logic [1:0] SR_TMP = 2'b10;

   // tmp mux
   localparam logic [2:0] TSEL_NONE = 3'b000;
   localparam logic [2:0] TSEL_R0   = 3'b001;
   localparam logic [2:0] TSEL_BIN  = 3'b010;

   // B mux (active values are rs-1)
   localparam logic [2:0] BSEL_IDLE = 3'b000;

   // ALU op
   localparam logic [1:0] ALU_XOR  = 2'b00;
   localparam logic [1:0] ALU_AND  = 2'b01;
   localparam logic [1:0] ALU_SHL  = 2'b10;
   localparam logic [1:0] ALU_IDLE = 2'b11;

   typedef struct packed {
      logic       w;
      logic [1:0] rn;
      logic [1:0] sr;
      logic       lt;
      logic [2:0] tsel;
      logic [2:0] bsel;
      logic [1:0] aluop;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{w: 1'b0, rn: 2'b00, sr: SR_IN, lt: 1'b0,
                                   tsel: TSEL_NONE, bsel: BSEL_IDLE, aluop: ALU_IDLE};

   typedef struct packed {
      logic       legal;
      logic       two_phase;
      logic [2:0] tsel;
      logic [1:0] sr;
      logic [1:0] aluop;
      logic [2:0] bsel;
   } dec_t;

endpackage

// File: rtl/dpseq_if.sv
// dpseq_if: instruction valid/ready channel into the sequencer.
//   instr_valid/op/rd/rs driven by the instruction source (master),
//   instr_ready driven by the sequencer (slave).
interface dpseq_if;
   import dpseq_pkg::*;

   logic             instr_valid;
   logic             instr_ready;
   logic [OP_W-1:0]  op;
   logic [REG_W-1:0] rd;
   logic [REG_W-1:0] rs;

   modport master (output instr_valid, op, rd, rs, input instr_ready);
   modport slave  (input instr_valid, op, rd, rs, output instr_ready);
endinterface

// File: rtl/dpseq_decode.sv
// dpseq_decode: combinational instruction decode.
//   op, rs  -> dec_c {legal, two_phase, tsel, sr, aluop, bsel}
//   rs=00 is illegal for MOV/XOR/AND; opcodes 101-111 are illegal.
module dpseq_decode
   import dpseq_pkg::*;
(
   input  logic [OP_W-1:0]  op,
   input  logic [REG_W-1:0] rs,
   output dec_t             dec_c
);

   logic [2:0] bsel_rs;

   // R1..R3 map onto B-mux inputs 0..2
   assign bsel_rs = 3'({1'b0, rs} - 3'd1);

   always_comb begin
      dec_c = '{legal: 1'b0, two_phase: 1'b0, tsel: TSEL_NONE, sr: SR_IN,
                aluop: ALU_IDLE, bsel: BSEL_IDLE};
      case (op)
         OP_LOAD: dec_c.legal = 1'b1;
         OP_MOV: begin
            dec_c.legal     = (rs != 2'b00);
            dec_c.two_phase = 1'b1;
            dec_c.tsel      = TSEL_BIN;
            dec_c.sr        = SR_TMP;
            dec_c.bsel      = bsel_rs;
         end
         OP_XOR: begin
            dec_c.legal     = (rs != 2'b00);
            dec_c.two_phase = 1'b1;
            dec_c.tsel      = TSEL_R0;
            dec_c.sr        = SR_ALU;
            dec_c.aluop     = ALU_XOR;
            dec_c.bsel      = bsel_rs;
         end
         OP_AND: begin
            dec_c.legal     = (rs != 2'b00);
            dec_c.two_phase = 1'b1;
            dec_c.tsel      = TSEL_R0;
            dec_c.sr        = SR_ALU;
            dec_c.aluop     = ALU_AND;
            dec_c.bsel      = bsel_rs;
         end
         OP_SHL: begin
            dec_c.legal     = 1'b1;
            dec_c.two_phase = 1'b1;
            dec_c.tsel      = TSEL_R0;
            dec_c.sr        = SR_ALU;
            dec_c.aluop     = ALU_SHL;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: expands one instruction at a time into timed
// datapath controls (IDLE -> [LDT] -> WB -> RET).
//   clk, rst_n          clock, async active-low reset
//   bus (dpseq_if.slave) instruction valid/ready channel with op/rd/rs
//   w, Rn, sr           register write enable / select / write-data mux
//   lt, tsel            tmp load strobe / tmp mux
//   bsel, aluop         B mux / ALU op
//   done, err           retire pulse / illegal-instruction flag
//   insn_count          retired legal instruction count (wraps)
// Build option DPSEQ_ILLEGAL_TRAP_EN: illegal instruction makes err sticky
// and holds instr_ready low until reset; otherwise it retires as a NOP
// with a one-cycle err pulse.
module datapath_sequencer
   import dpseq_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   dpseq_if.slave           bus,
   output logic             w,
   output logic [1:0]       Rn,
   output logic [1:0]       sr,
   output logic             lt,
   output logic [2:0]       tsel,
   output logic [2:0]       bsel,
   output logic [1:0]       aluop,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] insn_count
);

   state_e           state, state_nxt;
   ctrl_t            ctrl_q, ctrl_nxt;
   logic             ready_q, ready_nxt;
   logic             done_nxt, err_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   logic [OP_W-1:0]  op_q;
   logic [REG_W-1:0] rd_q, rs_q;

   logic             accept_c;
   logic [OP_W-1:0]  dec_op;
   logic [REG_W-1:0] dec_rs, dec_rd;
   dec_t             dec_c;
   ctrl_t            ldt_word, wb_word;

   assign accept_c = (state == S_IDLE) && bus.instr_valid && ready_q;

   // Decode the incoming instruction while idle, the latched one afterwards
   assign dec_op = (state == S_IDLE) ? bus.op : op_q;
   assign dec_rs = (state == S_IDLE) ? bus.rs : rs_q;
   assign dec_rd = (state == S_IDLE) ? bus.rd : rd_q;

   dpseq_decode u_decode (
      .op    (dec_op),
      .rs    (dec_rs),
      .dec_c (dec_c)
   );

   // Control words for the two active phases; bsel is carried in both
   always_comb begin
      ldt_word      = CTRL_IDLE;
      ldt_word.lt   = 1'b1;
      ldt_word.tsel = dec_c.tsel;
      ldt_word.bsel = dec_c.bsel;

      wb_word       = CTRL_IDLE;
      wb_word.w     = 1'b1;
      wb_word.rn    = dec_rd;
      wb_word.sr    = dec_c.sr;
      wb_word.aluop = dec_c.aluop;
      wb_word.bsel  = dec_c.bsel;
   end

   // Next state and next registered outputs
   always_comb begin
      state_nxt = state;
      ctrl_nxt  = CTRL_IDLE;
      ready_nxt = 1'b0;
      done_nxt  = 1'b0;
      cnt_nxt   = insn_count;
`ifdef DPSEQ_ILLEGAL_TRAP_EN
      err_nxt   = err;
`else
      err_nxt   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            ready_nxt = ready_q;
            if (accept_c) begin
               ready_nxt = 1'b0;
               if (!dec_c.legal) begin
                  state_nxt = S_RET;
                  done_nxt  = 1'b1;
                  err_nxt   = 1'b1;
               end else if (dec_c.two_phase) begin
                  state_nxt = S_LDT;
                  ctrl_nxt  = ldt_word;
               end else begin
                  state_nxt = S_WB;
                  ctrl_nxt  = wb_word;
               end
            end
         end
         S_LDT: begin
            state_nxt = S_WB;
            ctrl_nxt  = wb_word;
         end
         S_WB: begin
            state_nxt = S_RET;
            done_nxt  = 1'b1;
            cnt_nxt   = insn_count + CNT_W'(1);
         end
         S_RET: begin
            state_nxt = S_IDLE;
`ifdef DPSEQ_ILLEGAL_TRAP_EN
            ready_nxt = ~err;
`else
            ready_nxt = 1'b1;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ctrl_q     <= CTRL_IDLE;
         ready_q    <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         insn_count <= '0;
      end else begin
         state      <= state_nxt;
         ctrl_q     <= ctrl_nxt;
         ready_q    <= ready_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         insn_count <= cnt_nxt;
      end
   end

   // Instruction latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= '0;
         rd_q <= '0;
         rs_q <= '0;
      end else if (accept_c) begin
         op_q <= bus.op;
         rd_q <= bus.rd;
         rs_q <= bus.rs;
      end
   end

   assign bus.instr_ready = ready_q;
   assign w     = ctrl_q.w;
   assign Rn    = ctrl_q.rn;
   assign sr    = ctrl_q.sr;
   assign lt    = ctrl_q.lt;
   assign tsel  = ctrl_q.tsel;
   assign bsel  = ctrl_q.bsel;
   assign aluop = ctrl_q.aluop;

endmodule
